// File: rtl/conv_3x3_channel_accumulator_pkg.sv
// rtl/conv_3x3_channel_accumulator_pkg.sv - shared FSM states and arithmetic helpers for the channel accumulator
package conv_3x3_channel_accumulator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRST = 2'd1,
    ST_ACCUM = 2'd2,
    ST_LAST  = 2'd3
  } acc_state_t;

  function automatic int frame_len(input int w, input int h, input logic s2);
    return s2 ? (w / 2) * (h / 2) : w * h;
  endfunction

  // Operands arrive sign-extended to 64 bits; result is clamped to a dw-bit signed range.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int dw);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/conv_acc_frame_ram.sv
// rtl/conv_acc_frame_ram.sv - one-write one-read frame buffer with asynchronous read
module conv_acc_frame_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/conv_3x3_channel_accumulator.sv
// rtl/conv_3x3_channel_accumulator.sv - sums per-input-channel partial frames into one output frame
module conv_3x3_channel_accumulator
  import conv_3x3_channel_accumulator_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int IMAGE_WIDTH    = 16,
  parameter int IMAGE_HEIGHT   = 16,
  parameter int CHANNEL_NUM_IN = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stride2,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int PIX           = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int CNT_WIDTH_PIX = (PIX > 1) ? $clog2(PIX) : 1;
  localparam int CNT_WIDTH_CH  = $clog2(CHANNEL_NUM_IN) + 1;

  // Frame length is held as its last index so the wrap test is a plain equality.
  localparam logic [CNT_WIDTH_PIX-1:0] LAST_IDX_FULL =
    CNT_WIDTH_PIX'(frame_len(IMAGE_WIDTH, IMAGE_HEIGHT, 1'b0) - 1);
  localparam logic [CNT_WIDTH_PIX-1:0] LAST_IDX_S2 =
    CNT_WIDTH_PIX'(frame_len(IMAGE_WIDTH, IMAGE_HEIGHT, 1'b1) - 1);
  localparam logic [CNT_WIDTH_CH-1:0] LAST_CH = CNT_WIDTH_CH'(CHANNEL_NUM_IN - 1);

  acc_state_t              state, cur_state;
  logic [CNT_WIDTH_PIX-1:0] idx, cur_idx, last_idx, cur_last;
  logic [CNT_WIDTH_CH-1:0]  ch, cur_ch, ch_next;
  logic [DATA_WIDTH-1:0]    mem_rdata, acc_base, sum, wdata;
  logic                     we;

  // An IDLE cycle with valid_in is processed as the first sample of a new pass.
  always_comb begin
    cur_state = state;
    cur_idx   = idx;
    cur_ch    = ch;
    cur_last  = last_idx;
    if (state == ST_IDLE) begin
      cur_state = (CHANNEL_NUM_IN == 1) ? ST_LAST : ST_FIRST;
      cur_idx   = '0;
      cur_ch    = '0;
      cur_last  = stride2 ? LAST_IDX_S2 : LAST_IDX_FULL;
    end
    ch_next  = cur_ch + CNT_WIDTH_CH'(1);
    acc_base = (CHANNEL_NUM_IN == 1) ? '0 : mem_rdata;
    sum      = DATA_WIDTH'(sat_add(64'($signed(acc_base)), 64'($signed(pxl_in)), DATA_WIDTH));
    we       = valid_in && (cur_state != ST_LAST);
    wdata    = (cur_state == ST_FIRST) ? pxl_in : sum;
  end

  conv_acc_frame_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (PIX),
    .ADDR_WIDTH (CNT_WIDTH_PIX)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (cur_idx),
    .wdata (wdata),
    .raddr (cur_idx),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      ch         <= '0;
      last_idx   <= '0;
      pxl_out    <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      if (valid_in) begin
        last_idx <= cur_last;
        if (cur_state == ST_LAST) begin
          pxl_out   <= sum;
          valid_out <= 1'b1;
        end
        if (cur_idx != cur_last) begin
          idx   <= cur_idx + CNT_WIDTH_PIX'(1);
          ch    <= cur_ch;
          state <= cur_state;
          busy  <= 1'b1;
        end else begin
          idx <= '0;
          if (cur_state == ST_LAST) begin
            state      <= ST_IDLE;
            ch         <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end else begin
            ch    <= ch_next;
            state <= (ch_next == LAST_CH) ? ST_LAST : ST_ACCUM;
            busy  <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_3x3_channel_accumulator.sv
// tb/tb_conv_3x3_channel_accumulator.sv - randomized and directed bench against a frame-level reference model
module tb_conv_3x3_channel_accumulator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stride2;
  logic        valid_in;
  logic [31:0] pxl_in;

  logic [31:0] po0, po2, po3;
  logic [7:0]  po1;
  logic [3:0]  vo, fd, bz;

  int ch_num [4] = '{3, 2, 4, 1};
  int dw     [4] = '{32, 8, 32, 32};

  int n_vec = 0;
  int n_err = 0;

  bit     active   [4];
  int     mlen     [4];
  int     midx     [4];
  int     mch      [4];
  longint acc      [4][16];
  longint last_out [4];
  bit     exp_v    [4];
  bit     exp_d    [4];

  always #5 clk = ~clk;

  conv_3x3_channel_accumulator #(.DATA_WIDTH(32), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .CHANNEL_NUM_IN(3)) u_c3 (
    .clk(clk), .reset(reset_n), .stride2(stride2), .valid_in(valid_in), .pxl_in(pxl_in),
    .pxl_out(po0), .valid_out(vo[0]), .frame_done(fd[0]), .busy(bz[0]));

  conv_3x3_channel_accumulator #(.DATA_WIDTH(8), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .CHANNEL_NUM_IN(2)) u_c2 (
    .clk(clk), .reset(reset_n), .stride2(stride2), .valid_in(valid_in), .pxl_in(pxl_in[7:0]),
    .pxl_out(po1), .valid_out(vo[1]), .frame_done(fd[1]), .busy(bz[1]));

  conv_3x3_channel_accumulator #(.DATA_WIDTH(32), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .CHANNEL_NUM_IN(4)) u_c4 (
    .clk(clk), .reset(reset_n), .stride2(stride2), .valid_in(valid_in), .pxl_in(pxl_in),
    .pxl_out(po2), .valid_out(vo[2]), .frame_done(fd[2]), .busy(bz[2]));

  conv_3x3_channel_accumulator #(.DATA_WIDTH(32), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .CHANNEL_NUM_IN(1)) u_c1 (
    .clk(clk), .reset(reset_n), .stride2(stride2), .valid_in(valid_in), .pxl_in(pxl_in),
    .pxl_out(po3), .valid_out(vo[3]), .frame_done(fd[3]), .busy(bz[3]));

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint sext(input logic [31:0] d, input int w);
    logic [7:0] b;
    b = d[7:0];
    if (w == 8) return longint'($signed(b));
    return longint'($signed(d));
  endfunction

  function automatic longint sat(input longint s, input int w);
    longint hi;
    longint lo;
    hi = (64'sd1 <<< (w - 1)) - 1;
    lo = -hi - 1;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

  function automatic logic signed [63:0] dut_pxl(input int k);
    case (k)
      0:       return 64'($signed(po0));
      1:       return 64'($signed(po1));
      2:       return 64'($signed(po2));
      default: return 64'($signed(po3));
    endcase
  endfunction

  // Reference: each output frame is the running saturated sum of CH partial frames.
  task automatic step(input bit v, input logic [31:0] d, input bit s2, input bit rst);
    longint x;
    valid_in = v;
    pxl_in   = d;
    stride2  = s2;
    reset_n  = rst;
    for (int k = 0; k < 4; k++) begin
      exp_v[k] = 1'b0;
      exp_d[k] = 1'b0;
      if (!rst) begin
        active[k]   = 1'b0;
        last_out[k] = 0;
      end else if (v) begin
        if (!active[k]) begin
          active[k] = 1'b1;
          mlen[k]   = s2 ? 4 : 16;
          midx[k]   = 0;
          mch[k]    = 0;
        end
        x = sext(d, dw[k]);
        acc[k][midx[k]] = (mch[k] == 0) ? x : sat(acc[k][midx[k]] + x, dw[k]);
        if (mch[k] == ch_num[k] - 1) begin
          exp_v[k]    = 1'b1;
          last_out[k] = acc[k][midx[k]];
        end
        midx[k]++;
        if (midx[k] == mlen[k]) begin
          midx[k] = 0;
          mch[k]++;
          if (mch[k] == ch_num[k]) begin
            active[k] = 1'b0;
            exp_d[k]  = 1'b1;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("k%0d_valid_out", k), 64'(vo[k]), 64'(exp_v[k]));
      check($sformatf("k%0d_frame_done", k), 64'(fd[k]), 64'(exp_d[k]));
      check($sformatf("k%0d_busy", k), 64'(bz[k]), 64'(active[k]));
      check($sformatf("k%0d_pxl_out", k), dut_pxl(k), 64'(last_out[k]));
    end
  endtask

  initial begin
    valid_in = 1'b0;
    pxl_in   = '0;
    stride2  = 1'b0;
    reset_n  = 1'b0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Constant channels 1, 2, 3 over a full 4x4 frame.
    for (int c = 1; c <= 3; c++)
      for (int i = 0; i < 16; i++) step(1, 32'(c), 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // Saturation corners on short frames.
    step(1, 32'd100, 1, 1); step(1, -32'sd100, 1, 1); step(1, 32'd127, 1, 1); step(1, 32'd5, 1, 1);
    step(1, 32'd100, 1, 1); step(1, -32'sd100, 1, 1); step(1, -32'sd1, 1, 1); step(1, 32'd7, 1, 1);
    step(1, 32'h7fff_fff0, 1, 1); step(1, 32'h8000_0010, 1, 1); step(1, 32'd0, 1, 1); step(1, 32'd0, 1, 1);
    step(1, 32'h7fff_fff0, 1, 1); step(1, 32'h8000_0010, 1, 1); step(1, 32'd9, 1, 1); step(1, 32'd0, 1, 1);
    step(0, 0, 0, 0);

    // stride2 latched at pass start; toggling afterwards must not matter.
    for (int i = 0; i < 4; i++) step(1, 32'(i), (i % 2) == 0, 1);
    for (int i = 0; i < 4; i++) step(1, 32'(10 * i), (i % 2) == 1, 1);
    for (int i = 0; i < 8; i++) step(1, 32'(i + 3), i[0], 1);
    step(0, 0, 0, 0);

    // Random data with ~50% valid duty.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1);
    step(0, 0, 0, 0);

    // Reset partway through channel 1, then a clean pass over stale RAM.
    for (int i = 0; i < 23; i++) step(1, $urandom, 0, 1);
    step(0, 0, 0, 0);
    for (int i = 0; i < 64; i++) step(1, 32'($urandom_range(0, 2000)) - 32'd1000, 0, 1);

    // Continuous valid: back-to-back frames with no idle cycle.
    for (int i = 0; i < 200; i++) step(1, $urandom, 1'($urandom_range(0, 1)), 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
